// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter: FSM encoding and
// frame geometry.
package fifo_uart_pkg;

  localparam int WORD_W         = 16;
  localparam int BYTE_W         = 8;
  localparam int FRAME_BITS     = 10;
  localparam int BYTES_PER_WORD = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
module uart_baud_gen #(
  parameter int CLK_DIV = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  // NOTE: state registers use non-blocking assignments and the async reset branch
  // comes first, so every flop clears the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains 16-bit words from a FIFO and sends each as two 8N1 UART frames,
// low byte first, with at most one word in flight.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic [WORD_W-1:0] word_cnt
);

  state_t              state, state_nx;
  logic [WORD_W-1:0]   word_reg;
  logic                byte_sel;
  logic [2:0]          bit_idx;
  logic [BYTE_W-1:0]   cur_byte;
  logic                bit_end;
  logic                baud_clr;

  assign cur_byte = byte_sel ? word_reg[15:8] : word_reg[7:0];

  // Holding the timer at zero outside a frame makes START last exactly CLK_DIV cycles.
  assign baud_clr = (state == ST_IDLE) || (state == ST_LOAD);

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (baud_clr),
    .tick  (bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: next_state is defaulted before the case so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (en && !fifo_empty) state_nx = ST_LOAD;
      ST_LOAD:  state_nx = ST_START;
      ST_START: if (bit_end) state_nx = ST_DATA;
      ST_DATA:  if (bit_end && (bit_idx == 3'd7)) state_nx = ST_STOP;
      ST_STOP: begin
        if (bit_end) begin
          if (!byte_sel)                state_nx = ST_START;
          else if (en && !fifo_empty)   state_nx = ST_LOAD;
          else                          state_nx = ST_IDLE;
        end
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_reg <= '0;
      byte_sel <= 1'b0;
      bit_idx  <= '0;
      word_cnt <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          word_reg <= fifo_dout;
          byte_sel <= 1'b0;
          bit_idx  <= '0;
        end
        ST_START: if (bit_end) bit_idx <= '0;
        ST_DATA:  if (bit_end) bit_idx <= bit_idx + 3'd1;
        ST_STOP: begin
          if (bit_end) begin
            if (!byte_sel) byte_sel <= 1'b1;
            else           word_cnt <= word_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore-decoded outputs: tx returns high the instant reset forces IDLE.
  always_comb begin
    fifo_rd = (state == ST_LOAD);
    busy    = (state != ST_IDLE);
    case (state)
      ST_START: tx = 1'b0;
      ST_DATA:  tx = cur_byte[bit_idx];
      default:  tx = 1'b1;
    endcase
  end

endmodule
